adc_serial_reader: RTL

- Consumer side of the ADC power-down/ready handshake. Waits for ADC_ready from the ADC power-down controller, then frames serial conversions: it drives chip-select and shifts in each result from the ADC data line.
- Presents each result as a parallel sample to downstream logic with a valid/ready handshake.
- Sits between the ADC pins and the sample-processing datapath, in the clk_200kHz domain.

---
 rtl/adc_pkg.sv | 18 +
 rtl/adc_shift_capture.sv | 46 ++++
 rtl/adc_serial_reader.sv | 133 +++++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared types, default parameters and frame-length helper for the ADC serial reader.
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        SHIFT
    } adcState_t;

    localparam int DEF_DATA_BITS  = 12;
    localparam int DEF_LEAD_ZEROS = 4;
    localparam int DEF_GAP_CYCLES = 2;

    function automatic int FRAME_LEN(input int dataBits, input int leadZeros);
        return dataBits + leadZeros;
    endfunction

endpackage

// File: rtl/adc_shift_capture.sv
// Bit counter and MSB-first shift register for one ADC frame; strobes frame_done on the final bit.
module adc_shift_capture
    import adc_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int LEAD_ZEROS = DEF_LEAD_ZEROS
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_shift,
    input  logic                 i_sdata,
    output logic                 o_frame_done,
    output logic [DATA_BITS-1:0] o_word
);

    localparam int FRAME = FRAME_LEN(DATA_BITS, LEAD_ZEROS);
    localparam int CNT_W = $clog2(FRAME);

    logic [CNT_W-1:0]     r_bitCnt;
    logic [DATA_BITS-2:0] r_shift;
    logic                 w_last;
    logic                 w_keep;

    assign w_last = (r_bitCnt == CNT_W'(FRAME - 1));
    assign w_keep = (r_bitCnt >= CNT_W'(LEAD_ZEROS));

    // Counter restarts whenever shifting stops, so an aborted frame leaves no residue.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_bitCnt <= '0;
            r_shift  <= '0;
        end else if (i_shift) begin
            r_bitCnt <= w_last ? '0 : r_bitCnt + CNT_W'(1);
            if (w_keep) begin
                r_shift <= {r_shift[DATA_BITS-3:0], i_sdata};
            end
        end else begin
            r_bitCnt <= '0;
        end
    end

    // The final bit is still on the wire, so it is spliced in directly.
    assign o_frame_done = i_shift && w_last;
    assign o_word       = {r_shift, i_sdata};

endmodule

// File: rtl/adc_serial_reader.sv
// Frames serial ADC conversions once the ADC is ready and hands results downstream via valid/ready.
module adc_serial_reader
    import adc_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int LEAD_ZEROS = DEF_LEAD_ZEROS,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                 clk_200kHz,
    input  logic                 reset,
    input  logic                 ADC_ready,
    input  logic                 enable,
    input  logic                 adc_sdata,
    output logic                 adc_cs_n,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 overrun,
    output logic [15:0]          frame_count
);

    localparam int GAP_W = 4;

    adcState_t            r_state;
    adcState_t            w_nextState;
    logic [GAP_W-1:0]     r_gapCnt;
    logic                 r_csN;
    logic                 w_csNNext;
    logic                 w_shift;
    logic                 w_frameDone;
    logic [DATA_BITS-1:0] w_word;
    logic [DATA_BITS-1:0] r_sample;
    logic                 r_valid;
    logic                 r_overrun;
    logic [15:0]          r_frameCount;

    assign w_shift = (r_state == SHIFT) && ADC_ready;

    adc_shift_capture #(
        .DATA_BITS  (DATA_BITS),
        .LEAD_ZEROS (LEAD_ZEROS)
    ) u_capture (
        .i_clk        (clk_200kHz),
        .i_rst_n      (reset),
        .i_shift      (w_shift),
        .i_sdata      (adc_sdata),
        .o_frame_done (w_frameDone),
        .o_word       (w_word)
    );

    // Gap counter restarts on every entry into GAP.
    always_ff @(posedge clk_200kHz) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_gapCnt <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == GAP && w_nextState == GAP) begin
                r_gapCnt <= r_gapCnt + GAP_W'(1);
            end else begin
                r_gapCnt <= '0;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE: begin
                if (ADC_ready && enable) begin
                    w_nextState = GAP;
                end
            end
            GAP: begin
                if (!ADC_ready) begin
                    w_nextState = IDLE;
                end else if (r_gapCnt == GAP_W'(GAP_CYCLES - 1)) begin
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                if (!ADC_ready) begin
                    w_nextState = IDLE;
                end else if (w_frameDone) begin
                    w_nextState = enable ? GAP : IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Chip-select is registered from the next state so it tracks SHIFT exactly.
    always_comb begin
        w_csNNext = (w_nextState != SHIFT);
    end

    always_ff @(posedge clk_200kHz) begin
        if (!reset) begin
            r_csN <= 1'b1;
        end else begin
            r_csN <= w_csNNext;
        end
    end

    // A completed frame overwrites only a consumed (or simultaneously accepted) sample.
    always_ff @(posedge clk_200kHz) begin
        if (!reset) begin
            r_sample     <= '0;
            r_valid      <= 1'b0;
            r_overrun    <= 1'b0;
            r_frameCount <= '0;
        end else begin
            if (w_frameDone) begin
                r_frameCount <= r_frameCount + 16'd1;
                if (!r_valid || sample_ready) begin
                    r_sample <= w_word;
                    r_valid  <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && sample_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign adc_cs_n     = r_csN;
    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign overrun      = r_overrun;
    assign frame_count  = r_frameCount;

endmodule
